cacheline_adaptor: RTL and testbench

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cacheline_adaptor_pkg.sv | 27 ++
 rtl/cacheline_adaptor.sv | 130 +++++++++++++
 tb/tb_cacheline_adaptor.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// rtl/cacheline_adaptor_pkg.sv - shared states, default widths and size derivations for cacheline_adaptor
package cacheline_adaptor_pkg;

    localparam int DEF_LINE_W = 256;
    localparam int DEF_BEAT_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int nbeats(input int line_w, input int beat_w);
        return line_w / beat_w;
    endfunction

    // Byte-offset bits below a line-aligned address.
    function automatic int offset_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - cache line <-> memory burst adaptor; optional watchdog via CACHELINE_ADAPTOR_TIMEOUT_EN
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int LINE_W      = DEF_LINE_W,
    parameter int BEAT_W      = DEF_BEAT_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i,
    output logic              err_o
);

    localparam int NBEATS = nbeats(LINE_W, BEAT_W);
    localparam int KW     = cnt_w(NBEATS);
    localparam int OFFW   = offset_w(LINE_W);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFW) - 32'd1);

    state_t            state, state_nx;
    logic [KW-1:0]     k;
    logic [LINE_W-1:0] wline;
    logic [LINE_W-1:0] rbuf;
    logic [LINE_W-1:0] rbuf_nx;
    logic [LINE_W-1:0] line_q;
    logic [31:0]       addr_q;
    logic              busy;
    logic              last_beat;
    logic              tmo;

    assign busy      = (state == ST_READ) || (state == ST_WRITE);
    assign last_beat = busy && resp_i && (k == KW'(NBEATS - 1));

    always_comb begin
        rbuf_nx = rbuf;
        rbuf_nx[k*BEAT_W +: BEAT_W] = burst_i;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (read_i)       state_nx = ST_READ;
                else if (write_i) state_nx = ST_WRITE;
            end
            ST_READ, ST_WRITE: begin
                if (last_beat || tmo) state_nx = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            k      <= '0;
            wline  <= '0;
            rbuf   <= '0;
            line_q <= '0;
            addr_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    k <= '0;
                    if (read_i || write_i) addr_q <= address_i;
                    if (!read_i && write_i) wline <= line_i;
                end
                ST_READ: begin
                    if (resp_i) begin
                        rbuf <= rbuf_nx;
                        k    <= k + KW'(1);
                    end
                    // line_o only changes once the whole line has arrived
                    if (last_beat) line_q <= rbuf_nx;
                end
                ST_WRITE: begin
                    if (resp_i) k <= k + KW'(1);
                end
                default: k <= '0;
            endcase
        end
    end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tcnt;
    logic          err_q;

    assign tmo = busy && (tcnt == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if (!busy || resp_i) tcnt <= '0;
            else if (!tmo)       tcnt <= tcnt + TW'(1);
            // a real last beat wins over a coincident timeout
            err_q <= tmo && !last_beat;
        end
    end

    assign err_o = err_q;
`else
    assign tmo   = 1'b0;
    assign err_o = 1'b0;
`endif

    assign read_o    = (state == ST_READ);
    assign write_o   = (state == ST_WRITE);
    assign resp_o    = (state == ST_DONE);
    assign line_o    = line_q;
    assign address_o = addr_q & ADDR_MASK;
    assign burst_o   = (state == ST_WRITE) ? wline[k*BEAT_W +: BEAT_W] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - scoreboard bench for cacheline_adaptor with randomized bursts
module tb_cacheline_adaptor;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int NB     = LINE_W / BEAT_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [LINE_W-1:0] line_i = '0;
    logic [LINE_W-1:0] line_o;
    logic [31:0]       address_i = '0;
    logic              read_i = 1'b0;
    logic              write_i = 1'b0;
    logic              resp_o;
    logic [BEAT_W-1:0] burst_i = '0;
    logic [BEAT_W-1:0] burst_o;
    logic [31:0]       address_o;
    logic              read_o;
    logic              write_o;
    logic              resp_i = 1'b0;
    logic              err_o;

    cacheline_adaptor #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LINE_W-1:0] line;
        logic [31:0]       addr;
        logic              err;
    } exp_t;

    exp_t              exp_q[$];
    logic [BEAT_W-1:0] wbeat_q[$];
    int                checks = 0;
    int                failures = 0;
    int                done_cnt = 0;
    bit                busy = 1'b0;
    bit                kind_wr = 1'b0;
    logic [LINE_W-1:0] last_rd_line = '0;
    exp_t              me;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] aligned(input logic [31:0] a);
        return a - (a % (LINE_W / 8));
    endfunction

    // Monitor: pops expectations whenever the DUT completes or emits a write beat
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_o) begin
                done_cnt++;
                if (exp_q.size() == 0) check("resp_unexpected", resp_o, 0);
                else begin
                    me = exp_q.pop_front();
                    check("line_o", line_o, me.line);
                    check("address_o", address_o, me.addr);
                    check("err_o", err_o, me.err);
                end
            end else begin
                check("err_idle", err_o, 0);
            end
            if (write_o && resp_i) begin
                if (wbeat_q.size() == 0) check("burst_extra", write_o, 0);
                else check("burst_o", burst_o, wbeat_q.pop_front());
            end
            if (busy) begin
                check("read_o", read_o, !kind_wr);
                check("write_o", write_o, kind_wr);
            end
        end
    end

    // mode: 0 = back-to-back beats, 1 = gapped pattern, 2 = random gaps
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [LINE_W-1:0] data,
                           input int mode, input bit noise);
        int   gpat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int   n = 0;
        int   p = 0;
        int   prev;
        bit   give;
        exp_t e;
        @(posedge clk); #1;
        address_i = addr;
        resp_i    = 1'($urandom % 2);
        burst_i   = {$urandom, $urandom};
        if (wr) begin
            write_i = 1'b1;
            read_i  = 1'b0;
            line_i  = data;
            for (int i = 0; i < NB; i++) wbeat_q.push_back(data[i*BEAT_W +: BEAT_W]);
        end else begin
            read_i  = 1'b1;
            write_i = noise;
            line_i  = {8{$urandom}};
        end
        prev = done_cnt;
        @(posedge clk); #1;
        read_i  = 1'b0;
        write_i = 1'b0;
        kind_wr = wr;
        busy    = 1'b1;
        while (n < NB) begin
            if (mode == 0)      give = 1'b1;
            else if (mode == 1) give = (gpat[p % 7] != 0);
            else                give = ($urandom % 3 != 0);
            p++;
            resp_i  = give;
            burst_i = (give && !wr) ? data[n*BEAT_W +: BEAT_W] : {$urandom, $urandom};
            read_i  = noise && ($urandom % 4 == 0);
            if (give) n++;
            if (give && n == NB) begin
                if (!wr) last_rd_line = data;
                e.line = last_rd_line;
                e.addr = aligned(addr);
                e.err  = 1'b0;
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        busy   = 1'b0;
        @(negedge clk); #1;
        check("resp_count", done_cnt, prev + 1);
    endtask

    logic [LINE_W-1:0] rd_line;
    logic [LINE_W-1:0] wr_line;
    int                cyc;
    exp_t              te;

    initial begin
        #2;
        check("rst_line_o", line_o, 0);
        check("rst_address_o", address_o, 0);
        check("rst_ctrl", {read_o, write_o, resp_o, err_o}, 0);
        check("rst_burst_o", burst_o, 0);
        @(negedge clk); rst_n = 1'b1;

        rd_line = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
        run_txn(1'b0, 32'h0000_1234, rd_line, 0, 1'b0);
        wr_line = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
        run_txn(1'b1, 32'h0000_2000, wr_line, 0, 1'b0);
        rd_line = {8{$urandom}};
        run_txn(1'b0, 32'h0000_403F, rd_line, 1, 1'b0);
        rd_line = {8{$urandom}};
        run_txn(1'b0, 32'h8000_0011, rd_line, 2, 1'b1);

        // abort a read after two beats with an asynchronous reset
        @(posedge clk); #1;
        read_i = 1'b1; address_i = 32'h0000_5555;
        @(posedge clk); #1;
        read_i = 1'b0; resp_i = 1'b1; burst_i = 64'h1;
        @(posedge clk); #1;
        burst_i = 64'h2;
        @(posedge clk); #1;
        resp_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_line_o", line_o, 0);
        check("arst_address_o", address_o, 0);
        check("arst_ctrl", {read_o, write_o, resp_o, err_o}, 0);
        check("arst_burst_o", burst_o, 0);
        last_rd_line = '0;
        @(negedge clk); rst_n = 1'b1;
        rd_line = {8{$urandom}};
        run_txn(1'b0, 32'h0000_5555, rd_line, 0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            if ($urandom % 2 == 1) begin
                wr_line = {8{$urandom}};
                run_txn(1'b1, $urandom, wr_line, 2, 1'b1);
            end else begin
                rd_line = {8{$urandom}};
                run_txn(1'b0, $urandom, rd_line, 2, 1'b1);
            end
        end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        @(posedge clk); #1;
        read_i = 1'b1; address_i = 32'h0000_9990;
        te.line = last_rd_line; te.addr = aligned(32'h0000_9990); te.err = 1'b1;
        exp_q.push_back(te);
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            read_i = 1'b0;
            if (resp_o) break;
        end
        check("timeout_latency", cyc, 18);
        @(negedge clk);
`endif

        repeat (3) @(posedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("wbeat_q_drained", wbeat_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
